// File: rtl/dct_frame_sequencer.sv
// Streaming front-end for one dct core: clears its memory after reset, loads
// 8-sample frames, waits a settle interval and streams the 8 coefficients out.
module dct_frame_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             dct_reset,
  output logic             dct_wr,
  output logic             dct_oe,
  output logic [2:0]       dct_add,
  output logic [7:0]       dct_data_in,
  input  logic [7:0]       dct_data_out
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_LOAD,
    S_SETTLE,
    S_READ,
    S_CAPTURE,
    S_HOLD
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;

  state_t        state;
  state_t        next_state;
  logic [2:0]    cnt;
  logic [2:0]    k;
  logic [SW-1:0] settle_cnt;

  logic in_accept;
  logic out_accept;
  logic beat_last;

  assign in_accept  = (state == S_LOAD) && in_valid;
  assign out_accept = (state == S_HOLD) && out_valid && out_ready;
  assign beat_last  = (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_CLEAR: begin
        if (cnt == 3'd7) next_state = S_LOAD;
      end
      S_LOAD: begin
        if (in_accept && beat_last) next_state = (SETTLE_CYCLES == 0) ? S_READ : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) next_state = S_READ;
      end
      S_READ:    next_state = S_CAPTURE;
      S_CAPTURE: next_state = S_HOLD;
      S_HOLD: begin
        if (out_accept) next_state = (k == 3'd7) ? S_LOAD : S_READ;
      end
      default: next_state = S_CLEAR;
    endcase
  end

  // The DCT address comes straight from the counters so it only moves at an edge.
  always_comb begin
    in_ready  = 1'b0;
    dct_reset = 1'b0;
    dct_wr    = 1'b0;
    dct_oe    = 1'b0;
    dct_add   = cnt;
    unique case (state)
      S_CLEAR: begin
        dct_reset = 1'b1;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        dct_wr   = in_valid;
      end
      S_SETTLE: begin
        dct_add = cnt;
      end
      S_READ, S_CAPTURE, S_HOLD: begin
        dct_oe  = 1'b1;
        dct_add = k;
      end
      default: begin
        dct_add = cnt;
      end
    endcase
  end

  assign dct_data_in = in_data;
  assign busy        = !((state == S_LOAD) && (cnt == 3'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      k          <= '0;
      settle_cnt <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          cnt <= cnt + 3'd1;
        end
        S_LOAD: begin
          settle_cnt <= '0;
          k          <= '0;
          if (in_accept) begin
            cnt <= cnt + 3'd1;
            // in_last must mark exactly beat 7; the frame length never follows it.
            if (in_last != beat_last) frame_err <= 1'b1;
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + SW'(1);
        end
        S_READ: begin
        end
        S_CAPTURE: begin
          out_data  <= dct_data_out;
          out_idx   <= k;
          out_last  <= (k == 3'd7);
          out_valid <= 1'b1;
        end
        S_HOLD: begin
          if (out_accept) begin
            out_valid <= 1'b0;
            if (k == 3'd7) begin
              frame_cnt <= frame_cnt + CNT_W'(1);
              cnt       <= '0;
              k         <= '0;
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_frame_sequencer.sv
// Scoreboard bench for dct_frame_sequencer; a small behavioural memory stands
// in for the dct core and returns a known coefficient per address.
module tb_dct_frame_sequencer;

  localparam int SETTLE_CYCLES = 2;
  localparam int CNT_W         = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_idx;
  logic             out_last;
  logic             busy;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;
  logic             dct_reset;
  logic             dct_wr;
  logic             dct_oe;
  logic [2:0]       dct_add;
  logic [7:0]       dct_data_in;
  logic [7:0]       dct_data_out;

  always #5 clk = ~clk;

  dct_frame_sequencer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx),
    .out_last(out_last),
    .busy(busy),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt),
    .dct_reset(dct_reset),
    .dct_wr(dct_wr),
    .dct_oe(dct_oe),
    .dct_add(dct_add),
    .dct_data_in(dct_data_in),
    .dct_data_out(dct_data_out)
  );

  // Stand-in dct: 8-entry memory, reset clears only the addressed entry,
  // registered read returns a toy coefficient of the stored sample.
  function automatic logic [7:0] coef(input logic [7:0] sample, input int idx);
    return sample + 8'(17 * idx);
  endfunction

  logic [7:0] dct_mem [8];
  always @(posedge clk) begin
    if (dct_reset) dct_mem[dct_add] <= 8'd0;
    else if (dct_wr) dct_mem[dct_add] <= dct_data_in;
    if (dct_oe) dct_data_out <= coef(dct_mem[dct_add], int'(dct_add));
  end

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  int          ready_mode = 0;
  int          stall = 0;
  logic [15:0] exp_frames = '0;
  logic        exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic abortRun(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  initial begin
    #500000;
    abortRun("watchdog");
  end

  // Consumer side: out_ready pattern chosen by the running scenario.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid && out_idx == 3'd3 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        3: out_ready = !(out_valid && out_idx == 3'd5);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pops, write addressing, latency and hold stability.
  logic       prev_valid;
  logic       hold_pending;
  logic       cnt_pending;
  logic [2:0] wr_ptr;
  int         exp_rise;
  exp_t       held;
  exp_t       e;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_valid   = 1'b0;
      hold_pending = 1'b0;
      cnt_pending  = 1'b0;
      wr_ptr       = 3'd0;
      exp_rise     = -1;
    end else begin
      if (cnt_pending) begin
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        checkOutput("frame_err", 32'(frame_err), 32'(exp_err));
        cnt_pending = 1'b0;
      end
      if (dct_wr) begin
        checkOutput("wr_add", 32'(dct_add), 32'(wr_ptr));
        if (wr_ptr == 3'd7) exp_rise = cyc + 1 + SETTLE_CYCLES + 2;
        wr_ptr = wr_ptr + 3'd1;
      end
      if (hold_pending) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'(out_data), 32'(held.data));
        checkOutput("hold_idx", 32'(out_idx), 32'(held.idx));
        checkOutput("hold_add", 32'(dct_add), 32'(held.idx));
      end
      if (out_valid && !prev_valid) begin
        if (exp_rise < 0) begin
          checkOutput("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("latency", 32'(cyc), 32'(exp_rise));
        end
        exp_rise = -1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("extra_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(e.data));
          checkOutput("out_idx", 32'(out_idx), 32'(e.idx));
          checkOutput("out_last", 32'(out_last), 32'(e.last));
          if (e.last) begin
            exp_frames  = exp_frames + 16'd1;
            cnt_pending = 1'b1;
          end else begin
            exp_rise = cyc + 3;
          end
        end
      end
      hold_pending = out_valid && !out_ready;
      held         = '{data: out_data, idx: out_idx, last: out_last};
      prev_valid   = out_valid;
    end
  end

  // Producer: 8 beats with optional idle gaps; bad[b] flips in_last on beat b.
  task automatic applyStimulus(input logic [7:0][7:0] s, input logic [7:0] bad, input int max_gap);
    int waited;
    for (int b = 0; b < 8; b++) sb.push_back('{data: coef(s[b], b), idx: 3'(b), last: (b == 7)});
    if (bad != 8'd0) exp_err = 1'b1;
    for (int b = 0; b < 8; b++) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = s[b];
      in_last  = (b == 7) ^ bad[b];
      waited   = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!in_ready && waited < 500);
      if (!in_ready) abortRun("accept_timeout");
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain();
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(sb.size() == 0 && in_ready) && waited < 2000);
    if (waited >= 2000) abortRun("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic resetAndCheckClear();
    mon_en   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_frames = '0;
    exp_err    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
      end
      checkOutput("clr_dct_reset", 32'(dct_reset), 32'd1);
      checkOutput("clr_add", 32'(dct_add), 32'(i));
      checkOutput("clr_in_ready", 32'(in_ready), 32'd0);
      checkOutput("clr_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    checkOutput("load_in_ready", 32'(in_ready), 32'd1);
    checkOutput("load_busy", 32'(busy), 32'd0);
    checkOutput("load_dct_reset", 32'(dct_reset), 32'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    logic [7:0][7:0] s;
    int waited;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(posedge clk);
    resetAndCheckClear();

    $display("[TB] zero frame");
    ready_mode = 0;
    s = '0;
    applyStimulus(s, 8'h00, 0);
    waitDrain();

    $display("[TB] ramp frame 10..80");
    for (int b = 0; b < 8; b++) s[b] = 8'(10 * (b + 1));
    applyStimulus(s, 8'h00, 0);
    waitDrain();

    $display("[TB] backpressure on idx 3");
    stall = 0;
    ready_mode = 2;
    for (int b = 0; b < 8; b++) s[b] = 8'($urandom);
    applyStimulus(s, 8'h00, 1);
    waitDrain();
    checkOutput("stall_cycles", 32'(stall), 32'd5);

    $display("[TB] framing error then clean frame");
    ready_mode = 0;
    for (int b = 0; b < 8; b++) s[b] = 8'($urandom);
    applyStimulus(s, 8'b1001_0000, 0);
    waitDrain();
    for (int b = 0; b < 8; b++) s[b] = 8'($urandom);
    applyStimulus(s, 8'h00, 0);
    waitDrain();

    $display("[TB] random frames, random backpressure");
    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < 8; b++) s[b] = 8'($urandom);
      applyStimulus(s, 8'h00, 2);
      waitDrain();
    end

    $display("[TB] reset while holding idx 5");
    ready_mode = 3;
    for (int b = 0; b < 8; b++) s[b] = 8'($urandom);
    applyStimulus(s, 8'h00, 0);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(out_valid && out_idx == 3'd5) && waited < 500);
    if (waited >= 500) abortRun("hold5_timeout");
    resetAndCheckClear();

    $display("[TB] frame after reset");
    ready_mode = 1;
    for (int b = 0; b < 8; b++) s[b] = 8'($urandom);
    applyStimulus(s, 8'h00, 1);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dct_frame_sequencer.md
Name: dct_frame_sequencer

Overview:
- Sequences one `dct` instance as a streaming engine.
- Accepts 8-sample frames on a valid/ready input stream and writes them into the DCT sample memory via `wr`/`add`.
- Waits a settle interval, then reads the 8 coefficients via `oe`/`add` and emits them on a valid/ready output stream with index and last tags.
- Also performs the post-reset memory clear, because the DCT's own reset clears only the addressed location.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between the last write and the first read (0 allowed).
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_data  in  8  input sample.
- in_valid  in  1  input beat valid.
- in_ready  out  1  sequencer accepts a beat.
- in_last  in  1  producer marks beat 7 of the frame.
- out_data  out  8  coefficient.
- out_valid  out  1  coefficient valid.
- out_ready  in  1  consumer accepts.
- out_idx  out  3  coefficient index 0..7.
- out_last  out  1  high with idx 7.
- busy  out  1  frame in progress or clear running.
- frame_err  out  1  sticky in_last framing error.
- frame_cnt  out  CNT_W  frames fully emitted, wraps.
- dct_reset  out  1  to DCT `reset`.
- dct_wr  out  1  to DCT `wr`.
- dct_oe  out  1  to DCT `oe`.
- dct_add  out  3  to DCT `add`.
- dct_data_in  out  8  to DCT `data_in`.
- dct_data_out  in  8  from DCT `data_out`.

Behaviour:
- States: CLEAR, LOAD, SETTLE, READ, CAPTURE, HOLD. Counters: cnt (3b), k (3b), settle counter.
- out_*, frame_err and frame_cnt are registered. in_ready, busy and dct_* are combinational decodes of state, counters and inputs.
- reset: state=CLEAR, cnt=k=0, out_valid=0, out_data=0, out_idx=0, out_last=0, frame_err=0, frame_cnt=0.
  - reset wins over every other event.
  - A partial frame is discarded.
  - out_valid is low in the cycle after reset is sampled.
- CLEAR:
  - dct_reset=1, dct_add=cnt, dct_wr=0, dct_oe=0, in_ready=0.
  - cnt increments each cycle; after cnt=7 go to LOAD with cnt=0. Duration is exactly 8 cycles.
- LOAD:
  - in_ready=1, dct_add=cnt, dct_data_in=in_data, dct_wr=in_valid.
  - On in_valid&in_ready, the DCT latches in_data at the same edge and cnt increments.
  - Framing error: in_last=1 on beat<7, or in_last=0 on beat 7, sets frame_err. The frame is never truncated or extended; exactly 8 beats are taken.
  - On acceptance of beat 7: cnt=0, go to SETTLE, or to READ if SETTLE_CYCLES=0.
- SETTLE:
  - in_ready=0, dct_wr=0, dct_oe=0.
  - Lasts SETTLE_CYCLES cycles, then READ with k=0.
- READ: dct_oe=1, dct_add=k for 1 cycle, then CAPTURE.
- CAPTURE:
  - dct_oe=1, dct_add=k.
  - At the end of the cycle: out_data<=dct_data_out, out_idx<=k, out_last<=(k==7), out_valid<=1. Go to HOLD.
- HOLD:
  - dct_oe=1, dct_add=k held. out_data, out_idx and out_last are stable while out_valid&!out_ready.
  - On out_valid&out_ready: out_valid<=0.
    - If k==7: frame_cnt++, go to LOAD with cnt=0.
    - Else: k++, go to READ.
- dct_add changes only at state/counter updates, so every DCT read sees a fresh address.
- dct_oe=0 and dct_wr=0 outside the states listed above. dct_reset=1 only in CLEAR. dct_data_in=in_data always.
- Latency:
  - Beat 7 accepted at edge E0 → out_valid rises at edge E0+SETTLE_CYCLES+2.
  - With out_ready=1, successive coefficients are 3 cycles apart; a full frame read takes 24 cycles.
- busy=1 except in LOAD with cnt=0.
- frame_cnt wraps from 2^CNT_W−1 to 0.
- frame_err clears only on reset.
- No input is accepted during SETTLE/READ/CAPTURE/HOLD; there is no overlap of frames.

Test Plan:
- Release reset → dct_reset=1 for exactly 8 cycles with dct_add 0,1,…,7 and in_ready=0; in_ready=1 on cycle 9; busy falls with it.
- Frame of 8×8'd0 with in_last on beat 7, out_ready=1 → 8 outputs of 8'd0, out_idx 0..7, out_last only on idx 7, first out_valid 4 cycles after the 8th accept, outputs 3 cycles apart, frame_cnt=1, frame_err=0.
- Frame 10,20,…,80 against a scoreboard that drives a standalone `dct` directly with the same writes and reads add=k with oe=1 → out_data matches for all k; dct_wr pulses exactly 8 times with dct_add 0..7.
- Backpressure: out_ready=0 for 5 cycles while idx 3 is valid → out_data, out_idx=3 and dct_add=3 are stable; no index is skipped or repeated; the frame completes with frame_cnt incremented once.
- in_last asserted on beat 4 and deasserted on beat 7 → frame_err=1 and stays 1; 8 beats are still accepted and 8 coefficients emitted; a following clean frame leaves frame_err=1.
- reset pulsed while HOLD at idx 5 → out_valid=0 next cycle, CLEAR sequence repeats, frame_cnt=0, frame_err=0; the next frame produces the idx 0..7 sequence normally.
